// File: rtl/toggle_cover_detect.sv
// Per-bit rise/fall toggle detector with sticky coverage map and distinct-point counter.
// Define TOGGLE_COVER_DEDUP_EN to pulse valid only on the first hit of each point.
module toggle_cover_detect #(
    parameter  int WIDTH = 20,
    localparam int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   sig,
    input  logic               en,
    input  logic               clear,
    output logic [2*WIDTH-1:0] valid,
    output logic [2*WIDTH-1:0] covered,
    output logic [CNT_W-1:0]   cover_cnt,
    output logic               all_covered
);

    typedef enum logic {DISARMED, ARMED} state_t;

    state_t             state, state_nx;
    logic               armed;
    logic [WIDTH-1:0]   sig_q;
    logic [2*WIDTH-1:0] hit;
    logic [2*WIDTH-1:0] new_hit;
    logic [2*WIDTH-1:0] valid_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               all_nx;

    function automatic logic [CNT_W-1:0] popcnt(input logic [2*WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            c = c + CNT_W'(v[k]);
        end
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DISARMED;
        end else begin
            state <= state_nx;
        end
    end

    // The first non-reset edge only loads sig_q; events start one cycle later.
    always_comb begin
        state_nx = state;
        armed    = 1'b0;
        unique case (state)
            DISARMED: state_nx = ARMED;
            ARMED: begin
                state_nx = ARMED;
                armed    = 1'b1;
            end
            default: state_nx = DISARMED;
        endcase
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit[2*i]   = armed & en & sig[i] & ~sig_q[i];
            hit[2*i+1] = armed & en & ~sig[i] & sig_q[i];
        end
    end

    assign new_hit = hit & ~covered;
    assign cnt_nx  = cover_cnt + popcnt(new_hit);
    assign all_nx  = (cnt_nx == CNT_W'(2*WIDTH));

`ifdef TOGGLE_COVER_DEDUP_EN
    assign valid_nx = new_hit;
`else
    assign valid_nx = hit;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q       <= '0;
            valid       <= '0;
            covered     <= '0;
            cover_cnt   <= '0;
            all_covered <= 1'b0;
        end else begin
            sig_q <= sig;
            if (clear) begin
                valid       <= '0;
                covered     <= '0;
                cover_cnt   <= '0;
                all_covered <= 1'b0;
            end else begin
                valid       <= valid_nx;
                covered     <= covered | hit;
                cover_cnt   <= cnt_nx;
                all_covered <= all_nx;
            end
        end
    end

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Scoreboard bench for toggle_cover_detect: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_toggle_cover_detect;

    localparam int W = 20;

`ifdef TOGGLE_COVER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [39:0] v;
        logic [5:0]  n;
        logic        a;
        logic        chk_cov;
        logic [39:0] cov;
    } exp_t;

    logic          clock;
    logic          reset;
    logic [W-1:0]  sig;
    logic          en;
    logic          clear;
    logic [39:0]   valid;
    logic [39:0]   covered;
    logic [5:0]    cover_cnt;
    logic          all_covered;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    toggle_cover_detect #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .sig         (sig),
        .en          (en),
        .clear       (clear),
        .valid       (valid),
        .covered     (covered),
        .cover_cnt   (cover_cnt),
        .all_covered (all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout got=running want=finished");
        $fatal(1);
    end

    // Monitor: one expectation per clock edge, checked half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (valid !== e.v) begin
                    errors++;
                    $display("FAIL %s valid: got=%h want=%h", e.name, valid, e.v);
                end
                checks++;
                if (cover_cnt !== e.n) begin
                    errors++;
                    $display("FAIL %s cnt: got=%0d want=%0d", e.name, cover_cnt, e.n);
                end
                checks++;
                if (all_covered !== e.a) begin
                    errors++;
                    $display("FAIL %s all: got=%b want=%b", e.name, all_covered, e.a);
                end
                if (e.chk_cov) begin
                    checks++;
                    if (covered !== e.cov) begin
                        errors++;
                        $display("FAIL %s covered: got=%h want=%h", e.name, covered, e.cov);
                    end
                end
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [W-1:0] s,
                        input logic e, input logic c, input logic [39:0] v,
                        input logic [5:0] n, input logic a,
                        input logic ck, input logic [39:0] cv);
        exp_t x;
        @(negedge clock);
        reset = r;
        sig   = s;
        en    = e;
        clear = c;
        @(posedge clock);
        x.name    = nm;
        x.v       = v;
        x.n       = n;
        x.a       = a;
        x.chk_cov = ck;
        x.cov     = cv;
        q.push_back(x);
    endtask

    initial begin
        reset = 1'b1;
        sig   = 20'hFFFFF;
        en    = 1'b1;
        clear = 1'b0;

        for (int i = 0; i < 3; i++)
            step("rst", 1, 20'hFFFFF, 1, 0, 40'h0, 0, 0, 1, 40'h0);
        step("arm",   0, 20'hFFFFF, 1, 0, 40'h0, 0, 0, 1, 40'h0);
        step("hold",  0, 20'hFFFFF, 1, 0, 40'h0, 0, 0, 1, 40'h0);
        step("dis0",  0, 20'h00000, 0, 0, 40'h0, 0, 0, 1, 40'h0);
        step("ena0",  0, 20'h00000, 1, 0, 40'h0, 0, 0, 1, 40'h0);

        step("rise0", 0, 20'h00001, 1, 0, 40'h1, 1, 0, 1, 40'h1);
        step("fall0", 0, 20'h00000, 1, 0, 40'h2, 2, 0, 1, 40'h3);
        step("rise3", 0, 20'h00008, 1, 0, 40'h40, 3, 0, 1, 40'h43);
        step("fall3", 0, 20'h00000, 1, 0, 40'h80, 4, 0, 1, 40'hC3);
        step("rise3b", 0, 20'h00008, 1, 0, DEDUP ? 40'h0 : 40'h40, 4, 0, 1, 40'hC3);
        step("fall3b", 0, 20'h00000, 1, 0, DEDUP ? 40'h0 : 40'h80, 4, 0, 1, 40'hC3);

        step("en0up", 0, 20'hFFFFF, 0, 0, 40'h0, 4, 0, 1, 40'hC3);
        step("en1hd", 0, 20'hFFFFF, 1, 0, 40'h0, 4, 0, 1, 40'hC3);
        step("allfl", 0, 20'h00000, 1, 0,
             DEDUP ? 40'hAAAAAAAA28 : 40'hAAAAAAAAAA, 22, 0, 1, 40'hAAAAAAAAEB);
        step("allrs", 0, 20'hFFFFF, 1, 0,
             DEDUP ? 40'h5555555514 : 40'h5555555555, 40, 1, 1, 40'hFFFFFFFFFF);

        step("clr",   0, 20'h00000, 1, 1, 40'h0, 0, 0, 1, 40'h0);
        step("postc", 0, 20'h00000, 1, 0, 40'h0, 0, 0, 1, 40'h0);
        step("armkp", 0, 20'h00001, 1, 0, 40'h1, 1, 0, 1, 40'h1);
        step("tgl",   0, 20'h00003, 1, 0, 40'h4, 2, 0, 1, 40'h5);
        step("rstm",  1, 20'h00000, 1, 0, 40'h0, 0, 0, 1, 40'h0);
        step("prst",  0, 20'h00002, 1, 0, 40'h0, 0, 0, 1, 40'h0);
        step("prst2", 0, 20'h00000, 1, 0, 40'h8, 1, 0, 1, 40'h8);
        step("alt1",  0, 20'h00001, 1, 0, 40'h1, 2, 0, 1, 40'h9);
        step("alt0",  0, 20'h00000, 1, 0, 40'h2, 3, 0, 1, 40'hB);
        step("alt1b", 0, 20'h00001, 1, 0, DEDUP ? 40'h0 : 40'h1, 3, 0, 1, 40'hB);

        repeat (2) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
